// File: rtl/alu_arb_if.sv
// ----------------------------------------------------------------------------
// alu_arb_if : request/response bundle between two requesters and alu_arb.
//   req[1:0]        request lines, one per requester
//   op0/a0/b0       requester 0 operation and sign-magnitude operands
//   op1/a1/b1       requester 1 operation and sign-magnitude operands
//   gnt[1:0]        one-hot grant, held until the handshake completes
//   done[1:0]       one-hot completion, res/ovf valid while set
//   res[3:0], ovf   two's complement result and overflow flag
//   busy            arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface alu_arb_if;
   logic [1:0] req;
   logic       op0;
   logic [3:0] a0;
   logic [3:0] b0;
   logic       op1;
   logic [3:0] a1;
   logic [3:0] b1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic [3:0] res;
   logic       ovf;
   logic       busy;

   modport master (
      output req, op0, a0, b0, op1, a1, b1,
      input  gnt, done, res, ovf, busy
   );

   modport slave (
      input  req, op0, a0, b0, op1, a1, b1,
      output gnt, done, res, ovf, busy
   );
endinterface

// File: rtl/alu_arb.sv
// ----------------------------------------------------------------------------
// alu_arb : round-robin arbiter/sequencer sharing one 4-bit sign-magnitude
// add/sub datapath between two requesters using a four-phase req/done
// handshake.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   bus      alu_arb_if.slave (req, operands in; gnt, done, res, ovf, busy out)
//   ovf_cnt  [7:0] saturating count of overflowing results
//            (present only when ALU_ARB_OVFCNT_EN is defined)
// Parameters:
//   EXEC_CYCLES  cycles spent in EXEC before the result registers (1..15)
// Configuration macro: ALU_ARB_OVFCNT_EN adds the overflow counter.
// ----------------------------------------------------------------------------
module alu_arb #(
   parameter int EXEC_CYCLES = 1
) (
   input logic       clk,
   input logic       rst,
   alu_arb_if.slave  bus
`ifdef ALU_ARB_OVFCNT_EN
   ,
   output logic [7:0] ovf_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t     state_r;
   logic       ptr_r;      // requester favoured when both request
   logic       sel_r;      // requester currently being served
   logic       op_r;
   logic [3:0] a_r;
   logic [3:0] b_r;
   logic [3:0] cnt_r;

   logic       sel_s;
   logic [3:0] b_eff_s;
   logic [4:0] sum_s;
   logic [3:0] res_s;
   logic       ovf_s;

   // Sign-magnitude to 5-bit two's complement; -0 maps to 0.
   function automatic logic [4:0] conv5(input logic [3:0] x);
      logic [3:0] t;
      if (x[3]) begin
         t = {1'b1, ~x[2:0]} + 4'd1;
      end else begin
         t = x;
      end
      return {t[3], t};
   endfunction

   // Requester selection: a lone request wins, otherwise the pointer decides.
   always_comb begin
      sel_s = 1'b0;
      if (bus.req == 2'b11) begin
         sel_s = ptr_r;
      end else if (bus.req[1]) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   // Datapath on the latched operands. Subtraction flips b's sign bit;
   // the extra fifth bit exposes overflow as a disagreement of bits 4 and 3.
   always_comb begin
      b_eff_s = b_r;
      if (op_r) begin
         b_eff_s = {~b_r[3], b_r[2:0]};
      end else begin
         b_eff_s = b_r;
      end
      sum_s = conv5(a_r) + conv5(b_eff_s);
      res_s = sum_s[3:0];
      ovf_s = sum_s[4] ^ sum_s[3];
   end

   // Control FSM with registered outputs and operand latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         ptr_r    <= 1'b0;
         sel_r    <= 1'b0;
         op_r     <= 1'b0;
         a_r      <= 4'd0;
         b_r      <= 4'd0;
         cnt_r    <= 4'd0;
         bus.gnt  <= 2'b00;
         bus.done <= 2'b00;
         bus.res  <= 4'd0;
         bus.ovf  <= 1'b0;
         bus.busy <= 1'b0;
`ifdef ALU_ARB_OVFCNT_EN
         ovf_cnt  <= 8'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  sel_r    <= sel_s;
                  op_r     <= sel_s ? bus.op1 : bus.op0;
                  a_r      <= sel_s ? bus.a1  : bus.a0;
                  b_r      <= sel_s ? bus.b1  : bus.b0;
                  bus.gnt  <= sel_s ? 2'b10 : 2'b01;
                  cnt_r    <= CNT_LOAD;
                  bus.busy <= 1'b1;
                  state_r  <= EXEC;
               end else begin
                  state_r  <= IDLE;
               end
            end
            EXEC: begin
               if (cnt_r == 4'd0) begin
                  bus.res  <= res_s;
                  bus.ovf  <= ovf_s;
                  bus.done <= sel_r ? 2'b10 : 2'b01;
                  state_r  <= RESP;
`ifdef ALU_ARB_OVFCNT_EN
                  if (ovf_s && (ovf_cnt != 8'hFF)) begin
                     ovf_cnt <= ovf_cnt + 8'd1;
                  end else begin
                     ovf_cnt <= ovf_cnt;
                  end
`endif
               end else begin
                  cnt_r    <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               // res/ovf deliberately keep their values after the handshake.
               if (!bus.req[sel_r]) begin
                  bus.done <= 2'b00;
                  bus.gnt  <= 2'b00;
                  ptr_r    <= ~sel_r;
                  bus.busy <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  state_r  <= RESP;
               end
            end
            default: begin
               state_r  <= IDLE;
               bus.gnt  <= 2'b00;
               bus.done <= 2'b00;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arb.sv
// ----------------------------------------------------------------------------
// tb_alu_arb : self-checking bench for alu_arb (EXEC_CYCLES=4).
// Directed vector table, arbitration and reset sequences, then randomized
// traffic checked against an arithmetic/round-robin reference model.
// ----------------------------------------------------------------------------
module tb_alu_arb;

   localparam int EC = 4;

   logic clk;
   logic rst;
   alu_arb_if bus ();
`ifdef ALU_ARB_OVFCNT_EN
   logic [7:0] ovf_cnt;
`endif

   alu_arb #(.EXEC_CYCLES(EC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ALU_ARB_OVFCNT_EN
      ,
      .ovf_cnt (ovf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int         last_g;
   int         exp_cnt;
   logic [1:0] pend;
   logic       pop [2];
   logic [3:0] pa  [2];
   logic [3:0] pb  [2];

   typedef struct {
      logic       op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] r;
      logic       v;
   } vec_t;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Signed-value arithmetic straight from the number definitions.
   function automatic void model(input logic op, input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] r, output logic v);
      int va;
      int vb;
      int t;
      va = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
      vb = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
      t  = op ? (va - vb) : (va + vb);
      v  = (t > 7) || (t < -8);
      r  = t[3:0];
   endfunction

   task automatic raise(input int i, input logic op, input logic [3:0] a, input logic [3:0] b);
      pend[i] = 1'b1;
      pop[i]  = op;
      pa[i]   = a;
      pb[i]   = b;
      if (i == 0) begin
         bus.op0 = op; bus.a0 = a; bus.b0 = b;
      end else begin
         bus.op1 = op; bus.a1 = a; bus.b1 = b;
      end
      bus.req[i] = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_gnt",  16'(bus.gnt),  16'd0);
      chk("rst_done", 16'(bus.done), 16'd0);
      chk("rst_res",  16'(bus.res),  16'd0);
      chk("rst_ovf",  16'(bus.ovf),  16'd0);
      chk("rst_busy", 16'(bus.busy), 16'd0);
`ifdef ALU_ARB_OVFCNT_EN
      chk("rst_cnt",  16'(ovf_cnt),  16'd0);
`endif
      @(negedge clk);
      rst     = 1'b0;
      last_g  = 1;
      exp_cnt = 0;
   endtask

   // Wait for done on the requester the model picks, check, then release it.
   task automatic serve(input string tag, output logic [3:0] got_r, output logic got_v);
      int         lat;
      int         g;
      logic [3:0] er;
      logic       ev;
      logic [1:0] oh;
      g  = (pend == 2'b11) ? (1 - last_g) : (pend[1] ? 1 : 0);
      oh = (g == 1) ? 2'b10 : 2'b01;
      model(pop[g], pa[g], pb[g], er, ev);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            // operands after latch must be ignored
            if (g == 0) begin
               bus.op0 = ~pop[0]; bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
            end else begin
               bus.op1 = ~pop[1]; bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
            end
         end
      end while ((bus.done == 2'b00) && (lat < 60));
      chk({tag, "_lat"},  16'(lat),      16'(EC + 1));
      chk({tag, "_gnt"},  16'(bus.gnt),  16'(oh));
      chk({tag, "_done"}, 16'(bus.done), 16'(oh));
      chk({tag, "_res"},  16'(bus.res),  16'(er));
      chk({tag, "_ovf"},  16'(bus.ovf),  16'(ev));
      chk({tag, "_busy"}, 16'(bus.busy), 16'd1);
      got_r = bus.res;
      got_v = bus.ovf;
      @(posedge clk);
      #1;
      chk({tag, "_hold_done"}, 16'(bus.done), 16'(oh));
      chk({tag, "_hold_res"},  16'(bus.res),  16'(er));
      @(negedge clk);
      bus.req[g] = 1'b0;
      pend[g]    = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_rel_done"}, 16'(bus.done), 16'd0);
      chk({tag, "_rel_gnt"},  16'(bus.gnt),  16'd0);
      chk({tag, "_rel_busy"}, 16'(bus.busy), 16'd0);
      chk({tag, "_rel_res"},  16'(bus.res),  16'(er));
      last_g = g;
      if (ev && (exp_cnt < 255)) begin
         exp_cnt++;
      end
   endtask

   vec_t vecs [12];

   initial begin
      logic [3:0] r;
      logic       v;

      vecs[0]  = '{1'b0, 4'b0011, 4'b0010, 4'b0101, 1'b0}; // +3 + +2
      vecs[1]  = '{1'b1, 4'b0011, 4'b1010, 4'b0101, 1'b0}; // +3 - -2
      vecs[2]  = '{1'b0, 4'b0111, 4'b0010, 4'b1001, 1'b1}; // +7 + +2
      vecs[3]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0}; // -0 + 0
      vecs[4]  = '{1'b1, 4'b1000, 4'b1001, 4'b0001, 1'b0}; // -0 - -1
      vecs[5]  = '{1'b1, 4'b1111, 4'b0111, 4'b0010, 1'b1}; // -7 - +7
      vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b0010, 1'b1}; // -7 + -7
      vecs[7]  = '{1'b1, 4'b0111, 4'b1111, 4'b1110, 1'b1}; // +7 - -7
      vecs[8]  = '{1'b0, 4'b1011, 4'b0010, 4'b1111, 1'b0}; // -3 + +2
      vecs[9]  = '{1'b1, 4'b0000, 4'b1000, 4'b0000, 1'b0}; // 0 - -0
      vecs[10] = '{1'b0, 4'b1100, 4'b1100, 4'b1000, 1'b0}; // -4 + -4 = -8
      vecs[11] = '{1'b0, 4'b0100, 4'b0011, 4'b0111, 1'b0}; // +4 + +3 = +7

      rst     = 1'b1;
      pend    = 2'b00;
      bus.req = 2'b00;
      bus.op0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0;
      bus.op1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0;
      last_g  = 1;
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      apply_reset();

      // directed vector table, alternating requesters
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         raise(i % 2, vecs[i].op, vecs[i].a, vecs[i].b);
         serve($sformatf("vec%0d", i), r, v);
         chk($sformatf("vec%0d_tres", i), 16'(r), 16'(vecs[i].r));
         chk($sformatf("vec%0d_tovf", i), 16'(v), 16'(vecs[i].v));
      end

      // both requesting right after reset: grants go 0,1,0
      apply_reset();
      @(negedge clk);
      raise(0, 1'b0, 4'b0001, 4'b0010);
      raise(1, 1'b1, 4'b0101, 4'b0001);
      serve("arb0", r, v);
      @(negedge clk);
      raise(0, 1'b1, 4'b1010, 4'b0011);
      serve("arb1", r, v);
      @(negedge clk);
      raise(1, 1'b0, 4'b0110, 4'b1001);
      serve("arb2", r, v);
      serve("arb3", r, v);

      // reset in the middle of EXEC abandons the operation
      apply_reset();
      @(negedge clk);
      raise(0, 1'b0, 4'b0011, 4'b0010);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_busy", 16'(bus.busy), 16'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_gnt",  16'(bus.gnt),  16'd0);
      chk("mrst_done", 16'(bus.done), 16'd0);
      chk("mrst_busy", 16'(bus.busy), 16'd0);
      chk("mrst_res",  16'(bus.res),  16'd0);
      chk("mrst_ovf",  16'(bus.ovf),  16'd0);
      @(negedge clk);
      rst     = 1'b0;
      last_g  = 1;
      exp_cnt = 0;
      bus.op0 = pop[0]; bus.a0 = pa[0]; bus.b0 = pb[0];
      serve("after_rst", r, v);

      // randomized traffic with queued requests
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               raise(i, 1'($urandom), 4'($urandom), 4'($urandom));
            end
         end
         if (pend == 2'b00) begin
            raise(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 4'($urandom));
         end
         serve($sformatf("rnd%0d", n), r, v);
      end
      while (pend != 2'b00) begin
         serve("drain", r, v);
      end

`ifdef ALU_ARB_OVFCNT_EN
      chk("ovfcnt_rnd", 16'(ovf_cnt), 16'(exp_cnt));
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         raise(0, 1'b0, 4'b0111, 4'b0010);
         serve("sat", r, v);
      end
      chk("ovfcnt_sat", 16'(ovf_cnt), 16'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
